// File: rtl/pqr5_lsu.sv
// pqr5_lsu: single-outstanding load/store unit between execute and data memory.
// Optional misaligned-request drop is enabled by defining PQR5_LSU_MISALIGN_CHK_EN.
module pqr5_lsu #(
    parameter int AW    = 32,
    parameter int RSIZE = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_is_load,
    input  logic [2:0]       i_funct3,
    input  logic [AW-1:0]    i_addr,
    input  logic [RSIZE-1:0] i_wdata,
    input  logic [4:0]       i_rdaddr,
    output logic             o_dmem_req,
    input  logic             i_dmem_ack,
    output logic             o_dmem_we,
    output logic [AW-1:0]    o_dmem_addr,
    output logic [3:0]       o_dmem_be,
    output logic [RSIZE-1:0] o_dmem_wdata,
    input  logic             i_dmem_rvalid,
    input  logic [RSIZE-1:0] i_dmem_rdata,
    output logic             o_wb_valid,
    input  logic             i_wb_ready,
    output logic [4:0]       o_wb_rdaddr,
    output logic [RSIZE-1:0] o_wb_data,
    output logic             o_misalign
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, WB, MIS} state_t;
    state_t           state_q;
    logic             we_q;
    logic [AW-1:0]    addr_q;
    logic [2:0]       f3_q;
    logic [3:0]       be_q, be_d;
    logic [RSIZE-1:0] wdata_q, wdata_d;
    logic [4:0]       rd_q;
    logic [RSIZE-1:0] wb_data_q, ld_d, shifted;
    logic             mis_d;
    always_comb begin
        be_d    = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_addr[1:0] :
                  i_funct3[1:0] == 2'b01 ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
        wdata_d = i_funct3[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
                  i_funct3[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
        shifted = i_dmem_rdata >> {addr_q[1:0], 3'b000};
        // funct3[2] selects zero-extension; sizes 2 and 3 both return the full word
        ld_d    = f3_q[1] ? shifted :
                  f3_q[0] ? {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]} :
                            {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
    end
`ifdef PQR5_LSU_MISALIGN_CHK_EN
    assign mis_d      = i_funct3[1] ? |i_addr[1:0] : i_funct3[0] & i_addr[0];
    assign o_misalign = state_q == MIS;
`else
    assign mis_d      = 1'b0;
    assign o_misalign = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            f3_q      <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rd_q      <= '0;
            wb_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (i_req_valid) begin
                    we_q    <= ~i_is_load;
                    addr_q  <= i_addr;
                    f3_q    <= i_funct3;
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    rd_q    <= i_rdaddr;
                    state_q <= mis_d ? MIS : REQ;
                end
                REQ: if (i_dmem_ack) begin
                    state_q <= we_q ? IDLE : i_dmem_rvalid ? WB : RESP;
                    if (!we_q && i_dmem_rvalid) wb_data_q <= ld_d;
                end
                RESP: if (i_dmem_rvalid) begin
                    wb_data_q <= ld_d;
                    state_q   <= WB;
                end
                WB: if (i_wb_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign o_req_ready  = state_q == IDLE;
    assign o_dmem_req   = state_q == REQ;
    assign o_wb_valid   = state_q == WB;
    assign o_dmem_we    = we_q;
    assign o_dmem_addr  = {addr_q[AW-1:2], 2'b00};
    assign o_dmem_be    = be_q;
    assign o_dmem_wdata = wdata_q;
    assign o_wb_rdaddr  = rd_q;
    assign o_wb_data    = wb_data_q;
endmodule

// File: tb/tb_pqr5_lsu.sv
// tb_pqr5_lsu: directed and randomized load/store transactions checked against a
// byte-lane arithmetic model of the LSU.
module tb_pqr5_lsu;
    logic        clk = 0, srst = 1;
    logic        i_req_valid = 0, i_is_load = 0, i_dmem_ack = 0, i_dmem_rvalid = 0, i_wb_ready = 0;
    logic [2:0]  i_funct3 = 0;
    logic [31:0] i_addr = 0, i_wdata = 0, i_dmem_rdata = 0;
    logic [4:0]  i_rdaddr = 0;
    logic        o_req_ready, o_dmem_req, o_dmem_we, o_wb_valid, o_misalign;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
    logic [3:0]  o_dmem_be;
    logic [4:0]  o_wb_rdaddr;
    int checks = 0, failures = 0, hs = 0, exp_hs = 0;

    pqr5_lsu #(.AW(32), .RSIZE(32)) dut (
        .clk(clk), .srst(srst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_is_load(i_is_load), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdaddr(i_rdaddr), .o_dmem_req(o_dmem_req), .i_dmem_ack(i_dmem_ack),
        .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
        .o_dmem_wdata(o_dmem_wdata), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rdaddr(o_wb_rdaddr),
        .o_wb_data(o_wb_data), .o_misalign(o_misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (o_wb_valid && i_wb_ready) hs++;
    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        case (f3[1:0])
            2'd0: return 4'(1 << (a % 4));
            2'd1: return 4'(3 << (a & 2));
            default: return 4'd15;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'd0: return (w & 32'hFF) * 32'h01010101;
            2'd1: return (w & 32'hFFFF) * 32'h00010001;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        case (f3[1:0])
            2'd0: begin
                v = v & 32'hFF;
                if (!f3[2] && v > 127) v = v - 256;
            end
            2'd1: begin
                v = v & 32'hFFFF;
                if (!f3[2] && v > 32767) v = v - 65536;
            end
            default: ;
        endcase
        return v;
    endfunction

    // ad: cycles before ack; rvd: cycles from ack to rvalid; wbd: cycles wb_ready held low
    task automatic run_op(input bit ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [4:0] rda, input int ad, input int rvd, input int wbd);
        logic [31:0] eaddr;
        eaddr = {a[31:2], 2'b00};
        chk("ready_idle", o_req_ready, 1);
        i_req_valid = 1; i_is_load = ld; i_funct3 = f3; i_addr = a; i_wdata = wd; i_rdaddr = rda;
        step();
        i_req_valid = 0; i_addr = $urandom; i_wdata = $urandom; i_rdaddr = 5'($urandom); i_funct3 = 3'($urandom);
        chk("misalign_quiet", o_misalign, 0);
        for (int k = 0; k <= ad; k++) begin
            chk("dmem_req", o_dmem_req, 1);
            chk("ready_busy", o_req_ready, 0);
            chk("dmem_addr", o_dmem_addr, eaddr);
            chk("dmem_be", o_dmem_be, exp_be(f3, a));
            chk("dmem_we", o_dmem_we, !ld);
            if (!ld) chk("dmem_wdata", o_dmem_wdata, exp_wd(f3, wd));
            if (k == ad) begin
                i_dmem_ack = 1;
                if (ld && rvd == 0) begin i_dmem_rvalid = 1; i_dmem_rdata = rd; end
            end
            step();
        end
        i_dmem_ack = 0; i_dmem_rvalid = 0; i_dmem_rdata = $urandom;
        chk("dmem_req_drop", o_dmem_req, 0);
        if (!ld) begin
            chk("ready_after_st", o_req_ready, 1);
            return;
        end
        if (rvd > 0) begin
            for (int k = 1; k < rvd; k++) begin
                chk("wb_early", o_wb_valid, 0);
                step();
            end
            chk("wb_early", o_wb_valid, 0);
            i_dmem_rvalid = 1; i_dmem_rdata = rd;
            step();
            i_dmem_rvalid = 0; i_dmem_rdata = $urandom;
        end
        for (int k = 0; k <= wbd; k++) begin
            chk("wb_valid", o_wb_valid, 1);
            chk("wb_data", o_wb_data, exp_ld(f3, a, rd));
            chk("wb_rdaddr", o_wb_rdaddr, rda);
            if (k == wbd) i_wb_ready = 1;
            step();
        end
        i_wb_ready = 0;
        exp_hs++;
        chk("wb_drop", o_wb_valid, 0);
        chk("ready_after_ld", o_req_ready, 1);
        chk("wb_handshakes", hs, exp_hs);
    endtask

    initial begin
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        step();
        step();
        chk("rst_ready", o_req_ready, 1);
        chk("rst_dmem_req", o_dmem_req, 0);
        chk("rst_wb_valid", o_wb_valid, 0);
        chk("rst_dmem_be", o_dmem_be, 0);
        chk("rst_dmem_addr", o_dmem_addr, 0);
        chk("rst_wb_data", o_wb_data, 0);
        chk("rst_misalign", o_misalign, 0);
        srst = 0;
        step();
        run_op(0, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        run_op(0, 3'd0, 32'h103, 32'h000000A5, 0, 0, 0, 0, 0);
        run_op(0, 3'd1, 32'h102, 32'h1234CAFE, 0, 0, 1, 0, 0);
        run_op(1, 3'd0, 32'h102, 0, 32'h0080FF00, 5'd7, 0, 0, 0);
        run_op(1, 3'd4, 32'h102, 0, 32'h0080FF00, 5'd9, 0, 0, 0);
        run_op(1, 3'd1, 32'h102, 0, 32'h80011234, 5'd17, 3, 2, 2);
        run_op(1, 3'd5, 32'h102, 0, 32'h80011234, 5'd18, 0, 1, 0);
        // reset while waiting for read data
        i_req_valid = 1; i_is_load = 1; i_funct3 = 3'd2; i_addr = 32'h200; i_rdaddr = 5'd3;
        step();
        i_req_valid = 0; i_dmem_ack = 1;
        step();
        i_dmem_ack = 0;
        chk("resp_wait", o_wb_valid, 0);
        srst = 1;
        step();
        chk("abort_ready", o_req_ready, 1);
        chk("abort_dmem_req", o_dmem_req, 0);
        chk("abort_wb_valid", o_wb_valid, 0);
        chk("abort_dmem_addr", o_dmem_addr, 0);
        chk("abort_be", o_dmem_be, 0);
        chk("abort_we", o_dmem_we, 0);
        chk("abort_wdata", o_dmem_wdata, 0);
        chk("abort_wb_data", o_wb_data, 0);
        chk("abort_rdaddr", o_wb_rdaddr, 0);
        srst = 0; i_dmem_rvalid = 1; i_dmem_rdata = 32'h12345678; i_wb_ready = 1;
        step();
        i_dmem_rvalid = 0;
        step();
        chk("late_rvalid_wb", o_wb_valid, 0);
        step();
        i_wb_ready = 0;
        chk("late_rvalid_hs", hs, exp_hs);
`ifdef PQR5_LSU_MISALIGN_CHK_EN
        i_req_valid = 1; i_is_load = 1; i_funct3 = 3'd2; i_addr = 32'h102; i_rdaddr = 5'd4;
        step();
        i_req_valid = 0;
        chk("mis_pulse", o_misalign, 1);
        chk("mis_no_req", o_dmem_req, 0);
        step();
        chk("mis_pulse_end", o_misalign, 0);
        chk("mis_no_req2", o_dmem_req, 0);
        chk("mis_ready", o_req_ready, 1);
        chk("mis_no_wb", o_wb_valid, 0);
        chk("mis_hs", hs, exp_hs);
`else
        run_op(1, 3'd2, 32'h102, 0, 32'hA1B2C3D4, 5'd4, 0, 0, 0);
`endif
        for (int n = 0; n < 40; n++) begin
            bit ld;
            logic [2:0] f3;
            logic [31:0] a;
            ld = 1'($urandom);
            f3 = ld ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a = $urandom;
`ifdef PQR5_LSU_MISALIGN_CHK_EN
            if (f3[1]) a[1:0] = 2'b00;
            else if (f3[0]) a[0] = 1'b0;
`endif
            run_op(ld, f3, a, $urandom, $urandom, 5'($urandom), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("final_hs", hs, exp_hs);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
